fp_add_scheduler: RTL and testbench
===================================

Name: fp_add_scheduler

Overview:
- Shares one combinational Float_Add instance (X, Y → sum, XLEN-bit IEEE-754 single) between two requesters.
- Round-robin arbitration, a registered operand stage and a registered result stage.
- Response is held until the consumer accepts it.
- Sits between the ALU issue logic and the FP adder datapath, and adds status flags derived from the result exponent.

Parameters:
- XLEN, 32, operand/result width; exponent field is [30:23], mantissa [22:0], sign [31].
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle when valid&ready.
- req0_a  in  XLEN  requester 0 operand X.
- req0_b  in  XLEN  requester 0 operand Y.
- req1_valid, req1_ready, req1_a, req1_b  same as above, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_sum  out  XLEN  Float_Add result.
- rsp_overflow  out  1  rsp_sum[30:23] == 8'hFF.
- rsp_underflow  out  1  rsp_sum[30:23] == 0 and rsp_sum[22:0] != 0.
- rsp_zero  out  1  rsp_sum[30:0] == 0.
- busy  out  1  state != IDLE.
- ops_done  out  CNT_W  count of responses handed off.

Behaviour:
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection is combinational.
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester equal to rr_ptr is granted.
  - reqN_ready = (state==IDLE) & grant==N. At most one ready is high per cycle; ready does not depend on rsp_ready.
  - On handshake: latch a, b and id into operand registers; rr_ptr <= ~granted id; go to EXEC.
  - rr_ptr changes only on a grant. A lone requester may be granted back-to-back.
- EXEC (exactly 1 cycle):
  - Float_Add is driven from the operand registers.
  - Register sum and the three flags into the response registers; go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_sum and flags are stable until handshake.
  - On rsp_valid & rsp_ready: ops_done += 1 (wraps modulo 2^CNT_W); go to IDLE.
  - No new request is accepted in the handshake cycle; the next grant occurs in the following IDLE cycle.
- Latency and throughput:
  - Request handshake at cycle t → rsp_valid high at t+2.
  - With rsp_ready held high: one operation per 3 cycles.
- Flags:
  - Computed from the registered sum only, never from the inputs.
  - rsp_zero and rsp_underflow are mutually exclusive.
  - A zero result never raises underflow.
  - Sign of zero is passed through unmodified.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_sum=0, all flags=0, busy=0, ops_done=0. Both reqN_ready reflect IDLE grant logic after reset.
- Reset mid-operation:
  - rst in EXEC or RESP discards the in-flight operation; no response is produced and ops_done is not incremented.
  - The state next cycle is IDLE with all reset values.
- Requesters must hold valid/data stable until ready. Dropping valid without a handshake is permitted and has no effect.

Test Plan:
- Single request: req0 A=32'h3FC00000, B=32'h3FC00000 (1.5+1.5).
  → rsp_valid at t+2, rsp_id=0, rsp_sum=32'h40400000, all flags 0, ops_done=1 after accept.
- Contention: both valid every cycle, req0 (10.0+(-10.0), 41200000/C1200000), req1 (1.0+1.0, 3F800000/3F800000).
  → grants alternate 0,1,0,1 starting with 0.
  → id0 results: rsp_zero=1, rsp_underflow=0.
  → id1 results: rsp_sum=40000000.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid.
  → rsp_sum/id/flags stable.
  → req0_ready and req1_ready stay 0.
  → busy=1.
  → accept on cycle 6, then IDLE.
- Overflow: A=B=32'h7F000000.
  → rsp_sum[30:23]=8'hFF, rsp_overflow=1.
- Reset mid-op: assert rst in EXEC, then in RESP.
  → rsp_valid=0 next cycle, ops_done unchanged at 0, rr_ptr=0.
  → the next single req1 is granted normally.
- Counter wrap: CNT_W=4, issue 17 operations.
  → ops_done reads 1.

Source files
------------

// File: rtl/fp_add_scheduler.sv
// Two-requester scheduler around one shared combinational single-precision adder.
// Round-robin grant, registered operands, registered result held until accepted.
module fp_add_scheduler #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [XLEN-1:0]  rsp_sum,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic             rsp_zero,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    // state  | meaning
    // S_IDLE | arbitrate, accept one request
    // S_EXEC | adder evaluates latched operands, result captured
    // S_RESP | result presented until consumer accepts
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic             r_rr_ptr;
    logic [XLEN-1:0]  r_op_a;
    logic [XLEN-1:0]  r_op_b;
    logic             r_op_id;
    logic [XLEN-1:0]  r_rsp_sum;
    logic             r_rsp_id;
    logic             r_ovf;
    logic             r_unf;
    logic             r_zero;
    logic [CNT_W-1:0] r_ops_done;

    logic             w_grant_valid;
    logic             w_grant_id;
    logic [XLEN-1:0]  w_fa_sum;

    assign w_grant_valid = req0_valid | req1_valid;
    assign w_grant_id    = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;
    assign req0_ready    = (r_state == S_IDLE) & w_grant_valid & ~w_grant_id;
    assign req1_ready    = (r_state == S_IDLE) & w_grant_valid & w_grant_id;

    assign rsp_valid     = (r_state == S_RESP);
    assign rsp_id        = r_rsp_id;
    assign rsp_sum       = r_rsp_sum;
    assign rsp_overflow  = r_ovf;
    assign rsp_underflow = r_unf;
    assign rsp_zero      = r_zero;
    assign busy          = (r_state != S_IDLE);
    assign ops_done      = r_ops_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_id    <= 1'b0;
            r_rsp_sum  <= '0;
            r_rsp_id   <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_zero     <= 1'b0;
            r_ops_done <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_op_a   <= w_grant_id ? req1_a : req0_a;
                        r_op_b   <= w_grant_id ? req1_b : req0_b;
                        r_op_id  <= w_grant_id;
                        r_rr_ptr <= ~w_grant_id;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_sum <= w_fa_sum;
                    r_rsp_id  <= r_op_id;
                    r_ovf     <= (w_fa_sum[30:23] == 8'hFF);
                    r_unf     <= (w_fa_sum[30:23] == 8'h00) && (w_fa_sum[22:0] != 23'd0);
                    r_zero    <= (w_fa_sum[30:0] == 31'd0);
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_ops_done <= r_ops_done + CNT_W'(1);
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Float_Add: IEEE-754 single add, round-to-nearest-even, subnormals supported.
    logic [XLEN-1:0] w_big;
    logic [XLEN-1:0] w_small;
    logic            w_sub;
    logic            w_sign;
    logic [7:0]      w_eb;
    logic [7:0]      w_es;
    logic [7:0]      w_diff;
    logic [26:0]     w_mb;
    logic [26:0]     w_ms;
    logic [26:0]     w_ms_sh;
    logic [26:0]     w_lost;
    logic [27:0]     w_raw;
    logic [26:0]     w_norm;
    logic [9:0]      w_exp;
    logic [9:0]      w_sh;
    logic [4:0]      w_lz;
    logic            w_rup;
    logic [24:0]     w_rnd;
    logic [22:0]     w_man;

    always_comb begin
        w_big   = r_op_a;
        w_small = r_op_b;
        if (r_op_b[30:0] > r_op_a[30:0]) begin
            w_big   = r_op_b;
            w_small = r_op_a;
        end
        w_sub   = w_big[31] ^ w_small[31];
        w_eb    = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
        w_es    = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
        w_mb    = {(w_big[30:23] != 8'd0), w_big[22:0], 3'b000};
        w_ms    = {(w_small[30:23] != 8'd0), w_small[22:0], 3'b000};
        w_diff  = w_eb - w_es;
        w_lost  = '0;
        if (w_diff >= 8'd27) begin
            w_ms_sh = {26'd0, |w_ms};
        end else begin
            w_ms_sh    = w_ms >> w_diff;
            w_lost     = w_ms & ((27'd1 << w_diff) - 27'd1);
            w_ms_sh[0] = w_ms_sh[0] | (|w_lost);
        end
        w_raw  = w_sub ? ({1'b0, w_mb} - {1'b0, w_ms_sh}) : ({1'b0, w_mb} + {1'b0, w_ms_sh});
        // exact cancellation yields +0; like-signed zeros keep their sign
        w_sign = (w_sub && (w_raw == 28'd0)) ? 1'b0 : w_big[31];
        w_exp  = {2'b00, w_eb};
        w_lz   = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (w_raw[i]) w_lz = 5'(26 - i);
        end
        w_sh   = '0;
        w_norm = w_raw[26:0];
        if (w_raw[27]) begin
            w_norm = {w_raw[27:2], w_raw[1] | w_raw[0]};
            w_exp  = w_exp + 10'd1;
        end else begin
            w_sh   = ({5'd0, w_lz} < w_exp) ? {5'd0, w_lz} : (w_exp - 10'd1);
            w_norm = w_raw[26:0] << w_sh;
            w_exp  = w_exp - w_sh;
            if (!w_norm[26]) w_exp = 10'd0;
        end
        w_rup = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd = {1'b0, w_norm[26:3]} + 25'(w_rup);
        if (w_rnd[24]) begin
            w_man = w_rnd[23:1];
            w_exp = w_exp + 10'd1;
        end else begin
            w_man = w_rnd[22:0];
            if ((w_exp == 10'd0) && w_rnd[23]) w_exp = 10'd1;
        end
        if (w_exp >= 10'd255) w_fa_sum = {w_sign, 8'hFF, 23'd0};
        else                  w_fa_sum = {w_sign, w_exp[7:0], w_man};
        if ((r_op_a[30:23] == 8'hFF) || (r_op_b[30:23] == 8'hFF)) begin
            if (((r_op_a[30:23] == 8'hFF) && (r_op_a[22:0] != 23'd0)) ||
                ((r_op_b[30:23] == 8'hFF) && (r_op_b[22:0] != 23'd0)) ||
                ((r_op_a[30:23] == 8'hFF) && (r_op_b[30:23] == 8'hFF) && w_sub))
                w_fa_sum = 32'h7FC00000;
            else
                w_fa_sum = {w_big[31], 8'hFF, 23'd0};
        end
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler: arbitration, latency, backpressure,
// result flags, mid-operation reset and completed-operation counter wrap.
module tb_fp_add_scheduler;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [XLEN-1:0]  req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [XLEN-1:0]  req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [XLEN-1:0]  rsp_sum;
    logic             rsp_overflow, rsp_underflow, rsp_zero, busy;
    logic [CNT_W-1:0] ops_done;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    fp_add_scheduler #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow), .rsp_zero(rsp_zero),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic exp_id, input logic [31:0] exp_sum,
                           input logic [2:0] exp_flags);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, "_sum"}, rsp_sum, exp_sum);
        chk({tag, "_flags"}, 32'({rsp_overflow, rsp_underflow, rsp_zero}), 32'(exp_flags));
    endtask

    // Starts in IDLE just after a clock edge; ends in IDLE just after the accepting edge.
    task automatic run_one(input bit v0, input bit v1, input bit keep, input int stall,
                           input logic exp_id, input logic [31:0] exp_sum,
                           input logic [2:0] exp_flags);
        req0_valid = v0;
        req1_valid = v1;
        #1;
        chk("grant_req0_ready", 32'(req0_ready), 32'(exp_id == 1'b0));
        chk("grant_req1_ready", 32'(req1_ready), 32'(exp_id == 1'b1));
        @(posedge clk); #1;
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec_readies", 32'({req0_ready, req1_ready}), 32'd0);
        @(posedge clk); #1;
        chk_rsp("resp", exp_id, exp_sum, exp_flags);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk_rsp("stall", exp_id, exp_sum, exp_flags);
            chk("stall_readies", 32'({req0_ready, req1_ready}), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        chk("accept_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("accept_busy", 32'(busy), 32'd0);
        chk("accept_ops_done", 32'(ops_done), 32'(exp_cnt));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ops_done"}, 32'(ops_done), 32'd0);
        chk({tag, "_rsp_sum"}, rsp_sum, 32'd0);
        chk({tag, "_rsp_id_flags"}, 32'({rsp_id, rsp_overflow, rsp_underflow, rsp_zero}), 32'd0);
        // both valid: a cleared rr_ptr must favour requester 0; valids drop before the edge
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk({tag, "_rr_req0_ready"}, 32'(req0_ready), 32'd1);
        chk({tag, "_rr_req1_ready"}, 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_readies_idle", 32'({req0_ready, req1_ready}), 32'd0);
        chk_reset_state("reset");

        // contention: 10+(-10) on port 0, 1+1 on port 1, grants alternate from 0
        req0_a = 32'h41200000; req0_b = 32'hC1200000;
        req1_a = 32'h3F800000; req1_b = 32'h3F800000;
        run_one(1, 1, 1, 0, 1'b0, 32'h00000000, 3'b001);
        run_one(1, 1, 1, 0, 1'b1, 32'h40000000, 3'b000);
        run_one(1, 1, 1, 0, 1'b0, 32'h00000000, 3'b001);
        run_one(1, 1, 1, 0, 1'b1, 32'h40000000, 3'b000);
        req0_valid = 1'b0; req1_valid = 1'b0;

        req0_a = 32'h3FC00000; req0_b = 32'h3FC00000;
        run_one(1, 0, 0, 0, 1'b0, 32'h40400000, 3'b000);

        req1_a = 32'h3F800000; req1_b = 32'h3F800000;
        run_one(0, 1, 0, 5, 1'b1, 32'h40000000, 3'b000);

        req0_a = 32'h7F000000; req0_b = 32'h7F000000;
        run_one(1, 0, 0, 0, 1'b0, 32'h7F800000, 3'b100);

        req1_a = 32'h00800000; req1_b = 32'h80400000;
        run_one(0, 1, 0, 0, 1'b1, 32'h00400000, 3'b010);

        req1_a = 32'h80000000; req1_b = 32'h80000000;
        run_one(0, 1, 0, 0, 1'b1, 32'h80000000, 3'b001);

        req0_a = 32'h3F800000; req0_b = 32'h33800000;
        run_one(1, 0, 0, 0, 1'b0, 32'h3F800000, 3'b000);
        req0_a = 32'h3F800000; req0_b = 32'h33C00000;
        run_one(1, 0, 0, 0, 1'b0, 32'h3F800001, 3'b000);

        // reset while in EXEC (after a port-0 grant, so rr_ptr was 1)
        req0_a = 32'h3FC00000; req0_b = 32'h3FC00000;
        req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        chk("rst_exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        chk_reset_state("rst_exec");

        // reset while in RESP
        req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_resp_valid_before", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state("rst_resp");

        req1_a = 32'h3F800000; req1_b = 32'h3F800000;
        run_one(0, 1, 0, 0, 1'b1, 32'h40000000, 3'b000);

        // 16 more operations: 17 since reset wraps a 4-bit counter to 1
        req0_a = 32'h3FC00000; req0_b = 32'h3FC00000;
        for (int i = 0; i < 16; i++) begin
            run_one(1, 0, 0, 0, 1'b0, 32'h40400000, 3'b000);
        end
        chk("wrap_ops_done", 32'(ops_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
